// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
//
// Serial-to-parallel UART receive stage for an 8N1 link running on a 16x
// oversampled clock (one bit period = 16 clk cycles). The serial line is
// brought into the clock domain through a two-flop synchronizer, the start bit
// is qualified at its mid point (short low glitches are rejected), the eight
// data bits are sampled LSB first in the middle of each bit, and the stop bit
// decides between a good frame (byte published, rx_status pulse) and a
// framing error (rx_error pulse, byte discarded).
//
// Ports
//   clk        in   1  bit-sample clock, 16x the baud rate
//   reset      in   1  asynchronous, active-low reset
//   uart_rx    in   1  serial line, asynchronous to clk, idle high
//   rx_data    out  8  last correctly framed byte, held until the next one
//   rx_status  out  1  one-cycle pulse: rx_data has just been updated
//   rx_error   out  1  one-cycle pulse: stop bit was sampled low
// -----------------------------------------------------------------------------
module uart_receiver (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_status,
  output logic       rx_error
);

  // Oversampling ratio; fixed to match the transmitter on the other end.
  localparam int OVERSAMPLE = 16;

  // Count value at the middle of the start bit, measured from START entry.
  localparam logic [3:0] HALF_CNT = 4'(OVERSAMPLE / 2 - 1);
  // Count value at the end of a full bit period (mid-bit of the next bit).
  localparam logic [3:0] LAST_CNT = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] LAST_BIT = 3'd7;

  typedef enum logic [2:0] {
    WAIT_HIGH = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4
  } state_t;

  // Synchronizer stages
  logic       r_s1;
  logic       r_s_rx;

  // FSM and datapath state
  state_t     r_state;
  logic [3:0] r_count;
  logic [2:0] r_bit_idx;
  logic [7:0] r_shift;
  logic [7:0] r_rx_data;
  logic       r_rx_status;
  logic       r_rx_error;

  // Next-state values
  state_t     w_state_nxt;
  logic [3:0] w_count_nxt;
  logic [2:0] w_bit_idx_nxt;
  logic [7:0] w_shift_nxt;
  logic [7:0] w_rx_data_nxt;
  logic       w_rx_status_nxt;
  logic       w_rx_error_nxt;

  // Two-flop synchronizer; resets low so a line that is low at reset release
  // is seen as low and parks the FSM in WAIT_HIGH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1   <= 1'b0;
      r_s_rx <= 1'b0;
    end else begin
      r_s1   <= uart_rx;
      r_s_rx <= r_s1;
    end
  end

  // FSM state, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= WAIT_HIGH;
      r_count     <= 4'd0;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'h00;
      r_rx_data   <= 8'h00;
      r_rx_status <= 1'b0;
      r_rx_error  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_rx_data   <= w_rx_data_nxt;
      r_rx_status <= w_rx_status_nxt;
      r_rx_error  <= w_rx_error_nxt;
    end
  end

  // Next-state and output decode; every decision looks only at r_s_rx.
  always_comb begin
    w_state_nxt     = r_state;
    w_count_nxt     = r_count;
    w_bit_idx_nxt   = r_bit_idx;
    w_shift_nxt     = r_shift;
    w_rx_data_nxt   = r_rx_data;
    w_rx_status_nxt = 1'b0;
    w_rx_error_nxt  = 1'b0;

    case (r_state)
      // Line must be seen high before any falling edge counts as a start bit.
      WAIT_HIGH: begin
        if (r_s_rx) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = WAIT_HIGH;
        end
      end

      IDLE: begin
        if (!r_s_rx) begin
          w_state_nxt = START;
          w_count_nxt = 4'd0;
        end else begin
          w_state_nxt = IDLE;
        end
      end

      // Re-check the line half a bit into the start bit; a high line here
      // means the falling edge was a glitch and is dropped silently.
      START: begin
        if (r_count == HALF_CNT) begin
          if (!r_s_rx) begin
            w_state_nxt   = DATA;
            w_count_nxt   = 4'd0;
            w_bit_idx_nxt = 3'd0;
          end else begin
            w_state_nxt   = IDLE;
            w_count_nxt   = 4'd0;
          end
        end else begin
          w_count_nxt = r_count + 4'd1;
        end
      end

      // Count is anchored at mid start bit, so each wrap lands mid data bit.
      DATA: begin
        w_count_nxt = r_count + 4'd1;
        if (r_count == LAST_CNT) begin
          w_shift_nxt[r_bit_idx] = r_s_rx;
          if (r_bit_idx == LAST_BIT) begin
            w_state_nxt = STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end else begin
          w_shift_nxt = r_shift;
        end
      end

      // A low stop bit is a framing error or a break: keep the old byte and
      // wait for the line to recover before hunting for the next start bit.
      STOP: begin
        w_count_nxt = r_count + 4'd1;
        if (r_count == LAST_CNT) begin
          if (r_s_rx) begin
            w_rx_data_nxt   = r_shift;
            w_rx_status_nxt = 1'b1;
            w_state_nxt     = IDLE;
          end else begin
            w_rx_error_nxt  = 1'b1;
            w_state_nxt     = WAIT_HIGH;
          end
        end else begin
          w_state_nxt = STOP;
        end
      end

      default: begin
        w_state_nxt = WAIT_HIGH;
        w_count_nxt = 4'd0;
      end
    endcase
  end

  assign rx_data   = r_rx_data;
  assign rx_status = r_rx_status;
  assign rx_error  = r_rx_error;

endmodule

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
//
// Self-checking bench for uart_receiver. A bit-level serial driver plays the
// role of the transmitter (16 clk cycles per bit, changes on the falling clock
// edge). A table of frames is applied in a loop and compared against
// hand-computed bytes, pulse counts and pulse timing; the multi-cycle corner
// cases (back-to-back, glitch, framing error with held-low line, reset
// mid-frame) are written out as explicit sequences.
//
// Timing convention: cyc increments on each rising edge. A frame whose start
// bit is driven at a falling edge has T0 = cyc+1. The pulse registered on edge
// T0+154 is observed at the following falling edge, where cyc == T0+154.
// -----------------------------------------------------------------------------
module tb_uart_receiver;

  logic       clk;
  logic       reset;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_status;
  logic       rx_error;

  int cyc;
  int errors;
  int checks;

  int status_cnt;
  int error_cnt;
  int last_status_cyc;
  int last_error_cyc;
  logic [7:0] status_data;

  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    logic [7:0] exp_data;
    int         exp_status;
    int         exp_error;
  } vec_t;

  vec_t vecs[6];

  uart_receiver dut (
    .clk       (clk),
    .reset     (reset),
    .uart_rx   (uart_rx),
    .rx_data   (rx_data),
    .rx_status (rx_status),
    .rx_error  (rx_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
  end

  // Pulse monitor: counts every cycle each pulse output is high.
  always @(negedge clk) begin
    if (rx_status) begin
      status_cnt      <= status_cnt + 1;
      last_status_cyc <= cyc;
      status_data     <= rx_data;
    end
    if (rx_error) begin
      error_cnt      <= error_cnt + 1;
      last_error_cyc <= cyc;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives start, 8 data bits LSB first and a stop bit of the given level.
  // Entered and left on a falling edge; the line is left at the stop level.
  task automatic send_frame(input logic [7:0] d, input logic stop, output int t0);
    uart_rx = 1'b0;
    t0 = cyc + 1;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      repeat (16) @(negedge clk);
    end
    uart_rx = stop;
    repeat (16) @(negedge clk);
  endtask

  initial begin
    int t0;
    int ta;
    int tb;
    int s0;
    int e0;

    cyc = 0;
    errors = 0;
    checks = 0;
    status_cnt = 0;
    error_cnt = 0;
    last_status_cyc = -1;
    last_error_cyc = -1;
    status_data = 8'h00;

    vecs[0] = '{data: 8'hA5, stop_ok: 1'b1, exp_data: 8'hA5, exp_status: 1, exp_error: 0};
    vecs[1] = '{data: 8'h00, stop_ok: 1'b1, exp_data: 8'h00, exp_status: 1, exp_error: 0};
    vecs[2] = '{data: 8'hFF, stop_ok: 1'b1, exp_data: 8'hFF, exp_status: 1, exp_error: 0};
    vecs[3] = '{data: 8'h01, stop_ok: 1'b1, exp_data: 8'h01, exp_status: 1, exp_error: 0};
    vecs[4] = '{data: 8'h7E, stop_ok: 1'b0, exp_data: 8'h01, exp_status: 0, exp_error: 1};
    vecs[5] = '{data: 8'h80, stop_ok: 1'b1, exp_data: 8'h80, exp_status: 1, exp_error: 0};

    // Reset state
    reset = 1'b0;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_status", rx_status, 0);
    check("reset_rx_error", rx_error, 0);
    reset = 1'b1;
    idle(10);

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      s0 = status_cnt;
      e0 = error_cnt;
      send_frame(vecs[i].data, vecs[i].stop_ok, t0);
      idle(20);
      check($sformatf("vec%0d_rx_data", i), rx_data, vecs[i].exp_data);
      check($sformatf("vec%0d_status_pulses", i), status_cnt - s0, vecs[i].exp_status);
      check($sformatf("vec%0d_error_pulses", i), error_cnt - e0, vecs[i].exp_error);
      if (vecs[i].exp_status == 1) begin
        check($sformatf("vec%0d_status_time", i), last_status_cyc - t0, 154);
        check($sformatf("vec%0d_status_data", i), status_data, vecs[i].exp_data);
      end else begin
        check($sformatf("vec%0d_error_time", i), last_error_cyc - t0, 154);
      end
    end

    // Back-to-back: 0x3C then 0xC3 with no idle gap
    s0 = status_cnt;
    e0 = error_cnt;
    send_frame(8'h3C, 1'b1, ta);
    check("b2b_first_data", status_data, 8'h3C);
    check("b2b_first_time", last_status_cyc - ta, 154);
    send_frame(8'hC3, 1'b1, tb);
    idle(10);
    check("b2b_gap", tb - ta, 160);
    check("b2b_second_time", last_status_cyc - tb, 154);
    check("b2b_second_data", rx_data, 8'hC3);
    check("b2b_pulses", status_cnt - s0, 2);
    check("b2b_errors", error_cnt - e0, 0);

    // Glitch: 4-cycle low pulse, then 0x5A 40 cycles later
    s0 = status_cnt;
    e0 = error_cnt;
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(40);
    check("glitch_no_status", status_cnt - s0, 0);
    check("glitch_no_error", error_cnt - e0, 0);
    send_frame(8'h5A, 1'b1, t0);
    idle(10);
    check("glitch_then_data", rx_data, 8'h5A);
    check("glitch_then_time", last_status_cyc - t0, 154);
    check("glitch_then_pulses", status_cnt - s0, 1);

    // Framing error: 0x81 with low stop bit, line held low 64 more cycles
    s0 = status_cnt;
    e0 = error_cnt;
    send_frame(8'h81, 1'b0, t0);
    repeat (64) @(negedge clk);
    check("ferr_error_pulses", error_cnt - e0, 1);
    check("ferr_error_time", last_error_cyc - t0, 154);
    check("ferr_no_status", status_cnt - s0, 0);
    check("ferr_data_kept", rx_data, 8'h5A);
    idle(20);
    send_frame(8'h42, 1'b1, t0);
    idle(10);
    check("ferr_then_data", rx_data, 8'h42);
    check("ferr_then_time", last_status_cyc - t0, 154);
    check("ferr_then_pulses", status_cnt - s0, 1);
    check("ferr_then_errors", error_cnt - e0, 1);

    // Reset mid-frame of 0xFF at about T0+70
    uart_rx = 1'b0;
    t0 = cyc + 1;
    repeat (16) @(negedge clk);
    uart_rx = 1'b1;
    while (cyc < t0 + 69) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mid_rx_data", rx_data, 8'h00);
    check("rst_mid_rx_status", rx_status, 0);
    check("rst_mid_rx_error", rx_error, 0);
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    s0 = status_cnt;
    e0 = error_cnt;
    reset = 1'b1;
    repeat (20) @(negedge clk);
    idle(200);
    check("rst_mid_no_status", status_cnt - s0, 0);
    check("rst_mid_no_error", error_cnt - e0, 0);
    check("rst_mid_data_cleared", rx_data, 8'h00);
    send_frame(8'h96, 1'b1, t0);
    idle(10);
    check("rst_then_data", rx_data, 8'h96);
    check("rst_then_time", last_status_cyc - t0, 154);
    check("rst_then_pulses", status_cnt - s0, 1);
    check("rst_then_errors", error_cnt - e0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
